bus_frame_receiver: RTL

BUS_FRAME_RECEIVER -- requirements
Module: bus_frame_receiver

---
 rtl/bus_frame_receiver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver
//   Serial frame receiver for a shared single-wire bus. It samples one bit per
//   clock and checks each frame's CRC-4 and stop bit. Frames that pass the
//   address filter are presented on a valid/ready holding register.
//
//   Frame layout, in bus order with every field MSB first:
//     start(0) | src[3:0] | dst[3:0] | mod[1:0] | data[63:0] | crc[3:0] | stop(1)
//
// Ports
//   clock      : system clock; all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   busIn      : sampled serial bus, idle level 1
//   myAddr     : this node's address, latched when the header completes
//   rxData     : payload of the last accepted frame
//   rxSrc      : sender address of the last accepted frame
//   rxMod      : mode field of the last accepted frame
//   rxValid    : rxData/rxSrc/rxMod hold an accepted frame
//   rxReady    : consumer takes the held frame when rxValid is 1
//   crcError   : one-cycle pulse when a frame's CRC mismatches
//   frameError : one-cycle pulse when a frame's stop bit is 0
//   overflow   : sticky; an accepted frame was lost because the holding
//                register was full
module bus_frame_receiver #(
  parameter int FRAME_BITS = 80
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        busIn,
  input  logic [3:0]  myAddr,
  output logic [63:0] rxData,
  output logic [3:0]  rxSrc,
  output logic [1:0]  rxMod,
  output logic        rxValid,
  input  logic        rxReady,
  output logic        crcError,
  output logic        frameError,
  output logic        overflow
);

  // Bits between the start and stop bits, and how many of those the CRC covers.
  localparam int SHIFT_BITS   = FRAME_BITS - 2;
  localparam int COVERED_BITS = SHIFT_BITS - 4;
  localparam logic [6:0] LAST_BIT  = 7'(SHIFT_BITS - 1);
  localparam logic [6:0] CRC_LIMIT = 7'(COVERED_BITS);
  // The header (src, dst, mod) is complete when bit index 9 is shifted in.
  localparam logic [6:0] HDR_LAST  = 7'd9;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, STOP} state_t;

  state_t                  state;
  logic [6:0]              bit_count;
  logic [3:0]              crc;
  logic [SHIFT_BITS-1:0]   shift_reg;
  logic [3:0]              node_addr;

  // Fields of the frame as they sit in the shift register once in STOP.
  logic [3:0]  frame_src;
  logic [3:0]  frame_dst;
  logic [1:0]  frame_mod;
  logic [63:0] frame_data;
  logic [3:0]  frame_crc;
  logic        addr_ok;
  logic        crc_fb;
  logic [3:0]  crc_step;

  assign frame_src  = shift_reg[77:74];
  assign frame_dst  = shift_reg[73:70];
  assign frame_mod  = shift_reg[69:68];
  assign frame_data = shift_reg[67:4];
  assign frame_crc  = shift_reg[3:0];

  // Own frames are never accepted. Mode 0 is unicast and mode 1 is broadcast.
  // Modes 2 and 3 are reserved and dropped.
  assign addr_ok = (frame_src != node_addr) &&
                   (((frame_mod == 2'd0) && (frame_dst == node_addr)) ||
                    (frame_mod == 2'd1));

  // Serial CRC-4 over x^4 + x + 1, MSB first.
  assign crc_fb   = crc[3] ^ busIn;
  assign crc_step = {crc[2:0], 1'b0} ^ (crc_fb ? 4'h3 : 4'h0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_IDLE;
      bit_count  <= '0;
      crc        <= '0;
      shift_reg  <= '0;
      node_addr  <= '0;
      rxData     <= '0;
      rxSrc      <= '0;
      rxMod      <= '0;
      rxValid    <= 1'b0;
      crcError   <= 1'b0;
      frameError <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      crcError   <= 1'b0;
      frameError <= 1'b0;

      // Consumer handshake. A frame loaded in STOP below overrides this.
      if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end

      case (state)
        WAIT_IDLE: begin
          if (busIn) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!busIn) begin
            state     <= SHIFT;
            bit_count <= '0;
            crc       <= '0;
          end
        end

        SHIFT: begin
          shift_reg <= {shift_reg[SHIFT_BITS-2:0], busIn};
          bit_count <= bit_count + 7'd1;
          if (bit_count < CRC_LIMIT) begin
            crc <= crc_step;
          end
          if (bit_count == HDR_LAST) begin
            node_addr <= myAddr;
          end
          if (bit_count == LAST_BIT) begin
            state <= STOP;
          end
        end

        STOP: begin
          if (!busIn) begin
            frameError <= 1'b1;
            state      <= WAIT_IDLE;
          end else begin
            state <= IDLE;
            if (frame_crc != crc) begin
              crcError <= 1'b1;
            end else if (addr_ok) begin
              // Load when the register is empty or is being emptied this
              // same cycle. Otherwise the new frame is lost.
              if (!rxValid || rxReady) begin
                rxData  <= frame_data;
                rxSrc   <= frame_src;
                rxMod   <= frame_mod;
                rxValid <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
